// File: rtl/reducer_pkg.sv
// Shared encodings for the multi-operand reducer: operation select and FSM states.
package reducer_pkg;

  localparam logic [1:0] MODE_MAX = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_SUM = 2'b10;
  localparam logic [1:0] MODE_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/reduce_alu.sv
// Combinational fold step: combines the running accumulator with one operand.
module reduce_alu
  import reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             sat_flag
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    y        = a;
    sat_flag = 1'b0;
    unique case (mode)
      MODE_MAX: y = (b > a) ? b : a;
      MODE_MIN: y = (b < a) ? b : a;
      MODE_SUM: begin
        // Carry out means the true sum no longer fits; clamp to all-ones.
        if (sum[WIDTH]) begin
          y        = '1;
          sat_flag = 1'b1;
        end else begin
          y = sum[WIDTH-1:0];
        end
      end
      MODE_XOR: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/multi_operand_reducer.sv
// Multi-cycle reducer: latches N operands on start, folds one per cycle, pulses done.
module multi_operand_reducer
  import reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [N*WIDTH-1:0]   operands,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ops_q [N];
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] acc_q;
  logic [IDXW-1:0]  idx_q;
  logic             sat_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  logic             accept;
  logic [WIDTH-1:0] alu_y;
  logic             alu_sat;

  reduce_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (acc_q),
    .b        (ops_q[idx_q]),
    .mode     (mode_q),
    .y        (alu_y),
    .sat_flag (alu_sat)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_q == LastIdx) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        for (int i = 0; i < int'(N); i++) ops_q[i] <= operands[i*WIDTH +: WIDTH];
        mode_q <= mode;
        acc_q  <= operands[0 +: WIDTH];
        idx_q  <= IDXW'(1);
        sat_q  <= 1'b0;
      end else if (state_q == S_RUN) begin
        acc_q <= alu_y;
        idx_q <= idx_q + IDXW'(1);
        sat_q <= sat_q | alu_sat;
        // Visible outputs change only when an operation completes.
        if (idx_q == LastIdx) begin
          result_q   <= alu_y;
          overflow_q <= sat_q | alu_sat;
        end
      end
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multi_operand_reducer.sv
// Directed bench: default N=4/WIDTH=5 instance plus an N=8/WIDTH=8 instance.
module tb_multi_operand_reducer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [19:0] operands;
  logic        busy, done, overflow;
  logic [4:0]  result;

  logic        start8;
  logic [1:0]  mode8;
  logic [63:0] operands8;
  logic        busy8, done8, overflow8;
  logic [7:0]  result8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_operand_reducer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .operands (operands),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  multi_operand_reducer #(
    .WIDTH (8),
    .N     (8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .mode     (mode8),
    .operands (operands8),
    .busy     (busy8),
    .done     (done8),
    .result   (result8),
    .overflow (overflow8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts an op at the current negedge, checks the 3 RUN cycles, returns in the DONE cycle.
  task automatic op4(input string tag, input logic [1:0] m, input logic [19:0] ops,
                     input logic [4:0] exp_res, input logic exp_ovf, input bit disturb);
    start    = 1'b1;
    mode     = m;
    operands = ops;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_run"}, 32'(done), 32'd0);
      if (disturb) begin
        start    = 1'b1;
        mode     = ~m;
        operands = ~ops ^ 20'(i * 12345);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'b00;
    operands  = '0;
    start8    = 1'b0;
    mode8     = 2'b00;
    operands8 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Operands {3,2,1,5} with op0=3.
    op4("max", 2'b00, {5'd5, 5'd1, 5'd2, 5'd3}, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("max_idle_done", 32'(done), 32'd0);
    chk("max_idle_result", 32'(result), 32'd5);
    op4("min", 2'b01, {5'd5, 5'd1, 5'd2, 5'd3}, 5'd1, 1'b0, 1'b0);
    @(negedge clk);
    op4("xor", 2'b11, {5'd5, 5'd1, 5'd2, 5'd3}, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    op4("sum", 2'b10, {5'd5, 5'd1, 5'd2, 5'd3}, 5'd11, 1'b0, 1'b0);
    @(negedge clk);

    // Saturating sum {20,15,1,0}: 35 clamps to 31 and stays there.
    op4("sum_sat", 2'b10, {5'd0, 5'd1, 5'd15, 5'd20}, 5'd31, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sat_hold_result", 32'(result), 32'd31);
    chk("sat_hold_ovf", 32'(overflow), 32'd1);
    op4("sum_ones", 2'b10, {5'd1, 5'd1, 5'd1, 5'd1}, 5'd4, 1'b0, 1'b0);

    // Back-to-back from DONE, with start pulses and bus changes during RUN.
    op4("b2b", 2'b01, {5'd9, 5'd30, 5'd7, 5'd12}, 5'd7, 1'b0, 1'b1);
    op4("b2b2", 2'b00, {5'd9, 5'd30, 5'd7, 5'd12}, 5'd30, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_idle_done", 32'(done), 32'd0);

    // Reset asserted in the 2nd RUN cycle aborts the operation.
    start    = 1'b1;
    mode     = 2'b10;
    operands = {5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    op4("after_abort", 2'b00, {5'd5, 5'd1, 5'd2, 5'd3}, 5'd5, 1'b0, 1'b0);
    @(negedge clk);

    // Wide instance: operands 0..7 with op5 = 255, max mode.
    start8    = 1'b1;
    mode8     = 2'b00;
    operands8 = {8'd7, 8'd6, 8'd255, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("w8_busy", 32'(busy8), 32'd1);
      chk("w8_done_run", 32'(done8), 32'd0);
      @(negedge clk);
    end
    chk("w8_done", 32'(done8), 32'd1);
    chk("w8_result", 32'(result8), 32'd255);
    chk("w8_ovf", 32'(overflow8), 32'd0);
    @(negedge clk);
    chk("w8_idle_done", 32'(done8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
